// File: rtl/apu_frame_sequencer.sv
// $4017 frame counter: divides the CPU clock into quarter/half-frame pulses,
// raises the frame IRQ in 4-step mode and applies the parity-delayed sequence reset.
`timescale 1ns/1ps
module apu_frame_sequencer #(
    parameter int unsigned STEP1 = 7457,
    parameter int unsigned STEP2 = 14913,
    parameter int unsigned STEP3 = 22371,
    parameter int unsigned STEP4 = 29829,
    parameter int unsigned STEP5 = 37281,
    parameter int          CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_status,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       mode
);

    localparam logic [CNT_W-1:0] C_STEP1   = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] C_STEP2   = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] C_STEP3   = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] C_STEP4   = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] C_STEP4M1 = CNT_W'(STEP4 - 1);
    localparam logic [CNT_W-1:0] C_STEP5   = CNT_W'(STEP5);

    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_inhibit;
    logic             r_irq;
    logic             r_parity;
    logic             r_pend;
    logic             r_pend_mode;
    logic [2:0]       r_delay;
    logic             r_imm;
    logic             r_qf;
    logic             r_hf;

    logic             w_reload;
    logic             w_wrap;
    logic             w_q;
    logic             w_h;
    logic             w_irq_set;
    logic             w_unused_bits;

    assign w_unused_bits = ^wr_data[5:0];

    // A new write on the reload cycle restarts the delay instead of reloading.
    assign w_reload = r_pend && !wr_en && (r_delay == 3'd1);
    assign w_wrap   = r_mode ? (r_cnt == C_STEP5) : (r_cnt == C_STEP4);

    always_comb begin
        w_q       = 1'b0;
        w_h       = 1'b0;
        w_irq_set = 1'b0;
        if (!w_reload) begin
            if (r_cnt == C_STEP1 || r_cnt == C_STEP3) begin
                w_q = 1'b1;
            end
            if (r_cnt == C_STEP2) begin
                w_q = 1'b1;
                w_h = 1'b1;
            end
            if (!r_mode) begin
                if (r_cnt == C_STEP4) begin
                    w_q = 1'b1;
                    w_h = 1'b1;
                end
                if ((r_cnt == C_STEP4M1 || r_cnt == C_STEP4) && !r_inhibit) begin
                    w_irq_set = 1'b1;
                end
            end else if (r_cnt == C_STEP5) begin
                w_q = 1'b1;
                w_h = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_inhibit   <= 1'b0;
            r_irq       <= 1'b0;
            r_parity    <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_mode <= 1'b0;
            r_delay     <= 3'd0;
            r_imm       <= 1'b0;
            r_qf        <= 1'b0;
            r_hf        <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
            r_qf     <= w_q | r_imm;
            r_hf     <= w_h | r_imm;
            r_imm    <= w_reload & r_pend_mode;

            if (w_reload) begin
                r_cnt  <= '0;
                r_mode <= r_pend_mode;
            end else if (w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (wr_en) begin
                r_pend      <= 1'b1;
                r_pend_mode <= wr_data[7];
                r_delay     <= r_parity ? 3'd4 : 3'd3;
                r_inhibit   <= wr_data[6];
            end else if (r_pend) begin
                if (r_delay == 3'd1) begin
                    r_pend <= 1'b0;
                end
                r_delay <= r_delay - 3'd1;
            end

            // Inhibit-write clear beats a same-cycle set; a set beats a status read.
            if (wr_en && wr_data[6]) begin
                r_irq <= 1'b0;
            end else if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (rd_status) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign quarter_frame = r_qf;
    assign half_frame    = r_hf;
    assign frame_irq     = r_irq;
    assign mode          = r_mode;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer; step values are shortened so several complete
// sequences fit in a short run. Expected pulses are queued and matched by a monitor.
`timescale 1ns/1ps
module tb_apu_frame_sequencer;

    localparam int S1 = 74;
    localparam int S2 = 149;
    localparam int S3 = 223;
    localparam int S4 = 298;
    localparam int S5 = 372;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_status;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;
    logic       mode;

    typedef struct {
        int   cyc;
        logic q;
        logic h;
    } ev_t;

    ev_t exp_q[$];
    int  cyc;
    int  n_tests;
    int  n_fail;
    logic mon_en;

    apu_frame_sequencer #(
        .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_status(rd_status),
        .quarter_frame(quarter_frame),
        .half_frame(half_frame),
        .frame_irq(frame_irq),
        .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges since reset release; cnt after edge k of a fresh sequence is k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        ev_t e;
        if (mon_en && rst_n && (quarter_frame || half_frame)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_pulse cyc=%0d q=%b h=%b, required no pulse", cyc, quarter_frame, half_frame);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e.cyc || quarter_frame !== e.q || half_frame !== e.h) begin
                    n_fail++;
                    $display("FAIL sb_pulse got cyc=%0d q=%b h=%b, required cyc=%0d q=%b h=%b",
                             cyc, quarter_frame, half_frame, e.cyc, e.q, e.h);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_ev(input int c, input logic q, input logic h);
        ev_t e;
        e.cyc = c;
        e.q   = q;
        e.h   = h;
        exp_q.push_back(e);
    endtask

    task automatic push_four(input int r);
        push_ev(r + S1 + 1, 1'b1, 1'b0);
        push_ev(r + S2 + 1, 1'b1, 1'b1);
        push_ev(r + S3 + 1, 1'b1, 1'b0);
        push_ev(r + S4 + 1, 1'b1, 1'b1);
    endtask

    // Returns the edge at which the deferred reload lands (3 or 4 edges after the write edge).
    task automatic do_write(input logic [7:0] d, output int r);
        wr_en   = 1'b1;
        wr_data = d;
        r = (cyc + 1) + (((cyc % 2) == 0) ? 3 : 4);
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = 8'h00;
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got %b, required %b (cyc=%0d)", name, got, req, cyc);
        end
    endtask

    task automatic check_sb_empty(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s got %0d missing pulses, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        check_bit("reset_qf", quarter_frame, 1'b0);
        check_bit("reset_hf", half_frame, 1'b0);
        check_bit("reset_irq", frame_irq, 1'b0);
        check_bit("reset_mode", mode, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_four_step;
        push_four(0);
        wait_cyc(S4 - 1);
        check_bit("irq_before_window", frame_irq, 1'b0);
        rd_status = 1'b1;
        @(negedge clk);
        rd_status = 1'b0;
        check_bit("irq_set_beats_rd", frame_irq, 1'b1);
        wait_cyc(S4 + 2);
        check_bit("irq_held_after_wrap", frame_irq, 1'b1);
        check_bit("mode_four_step", mode, 1'b0);
        check_sb_empty("four_step_pulses");
    endtask

    task automatic test_rd_clear;
        rd_status = 1'b1;
        @(negedge clk);
        rd_status = 1'b0;
        check_bit("rd_clears_irq", frame_irq, 1'b0);
        @(negedge clk);
        check_bit("irq_stays_clear", frame_irq, 1'b0);
    endtask

    task automatic test_five_step;
        int r;
        if ((cyc % 2) != 0) @(negedge clk);
        do_write(8'h80, r);
        push_ev(r + 1, 1'b1, 1'b1);
        push_ev(r + S1 + 1, 1'b1, 1'b0);
        push_ev(r + S2 + 1, 1'b1, 1'b1);
        push_ev(r + S3 + 1, 1'b1, 1'b0);
        push_ev(r + S5 + 1, 1'b1, 1'b1);
        wait_cyc(r - 1);
        check_bit("five_mode_before_reload", mode, 1'b0);
        wait_cyc(r);
        check_bit("five_mode_at_reload", mode, 1'b1);
        wait_cyc(r + S4 + 1);
        check_bit("five_no_irq", frame_irq, 1'b0);
        wait_cyc(r + S5 + 2);
        check_bit("five_no_irq_end", frame_irq, 1'b0);
        check_sb_empty("five_step_pulses");
    endtask

    task automatic test_four_step_restart;
        int r;
        if ((cyc % 2) == 0) @(negedge clk);
        do_write(8'h00, r);
        push_four(r);
        wait_cyc(r - 1);
        check_bit("restart_mode_before", mode, 1'b1);
        wait_cyc(r);
        check_bit("restart_mode_at_reload", mode, 1'b0);
        wait_cyc(r + S4 - 1);
        check_bit("restart_irq_before", frame_irq, 1'b0);
        wait_cyc(r + S4);
        check_bit("restart_irq_set", frame_irq, 1'b1);
        wait_cyc(r + S4 + 2);
        check_sb_empty("restart_pulses");
    endtask

    task automatic test_back_to_back;
        int r1;
        int r;
        int k;
        if ((cyc % 2) != 0) @(negedge clk);
        k = cyc;
        do_write(8'h80, r1);
        check_bit("write_no_inhibit_keeps_irq", frame_irq, 1'b1);
        do_write(8'h40, r);
        check_bit("inhibit_write_clears_irq", frame_irq, 1'b0);
        push_four(r);
        wait_cyc(k + 4);
        check_bit("b2b_first_replaced", mode, 1'b0);
        wait_cyc(r + 1);
        check_bit("b2b_mode_after_reload", mode, 1'b0);
        wait_cyc(r + S4);
        check_bit("inhibit_irq_window_a", frame_irq, 1'b0);
        @(negedge clk);
        check_bit("inhibit_irq_window_b", frame_irq, 1'b0);
        wait_cyc(r + S4 + 2);
        check_sb_empty("b2b_pulses");
    endtask

    task automatic test_reenable;
        int r;
        do_write(8'h00, r);
        push_four(r);
        wait_cyc(r + S4 - 1);
        check_bit("reenable_irq_before", frame_irq, 1'b0);
        wait_cyc(r + S4);
        check_bit("reenable_irq_set", frame_irq, 1'b1);
        wait_cyc(r + S4 + 2);
        check_sb_empty("reenable_pulses");
    endtask

    task automatic test_reset_mid;
        int r;
        do_write(8'h80, r);
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("async_reset_qf", quarter_frame, 1'b0);
        check_bit("async_reset_hf", half_frame, 1'b0);
        check_bit("async_reset_irq", frame_irq, 1'b0);
        check_bit("async_reset_mode", mode, 1'b0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        push_ev(S1 + 1, 1'b1, 1'b0);
        wait_cyc(8);
        check_bit("no_deferred_reload_mode", mode, 1'b0);
        wait_cyc(S1 + 2);
        check_bit("post_reset_mode", mode, 1'b0);
        check_bit("post_reset_irq", frame_irq, 1'b0);
        check_sb_empty("post_reset_pulses");
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        mon_en    = 1'b1;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        rd_status = 1'b0;
        test_reset;
        test_four_step;
        test_rd_clear;
        test_five_step;
        test_four_step_restart;
        test_back_to_back;
        test_reenable;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
